// File: rtl/pe_rf_pkg.sv
// Shared types and helpers for the pe_regfile_mp register file slice.
// Optional same-cycle write bypass is enabled with the macro PE_RF_BYPASS_EN.
package pe_rf_pkg;

    // Clear sequencer states
    typedef enum logic {
        PE_RF_IDLE  = 1'b0,
        PE_RF_CLEAR = 1'b1
    } pe_rf_state_e;

    // Channel index map for the default three-channel PE
    localparam int PE_CH_EDGE8  = 0;
    localparam int PE_CH_EDGE11 = 1;
    localparam int PE_CH_BUS    = 2;

    // Widest select vector the legality helper accepts; callers zero-extend
    localparam int SEL_MAX_W = 32;

    // True when exactly one select bit is set
    function automatic logic onehot_legal(input logic [SEL_MAX_W-1:0] sel);
        return ($countones(sel) == 1);
    endfunction

endpackage

// File: rtl/pe_rf_onehot_mux.sv
// N-way one-hot data mux: a legal one-hot select passes the chosen lane,
// a zero or multi-hot select drives zero and clears legal.
module pe_rf_onehot_mux
    import pe_rf_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] data_in,
    output logic [W-1:0]   data_out,
    output logic           legal
);

    // Select the lane addressed by a legal one-hot select, zero otherwise
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        data_out = '0;
        legal    = onehot_legal(SEL_MAX_W'(sel));
        if (legal) begin
            for (int i = 0; i < N; i++) begin
                if (sel[i]) data_out = data_in[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/pe_regfile_mp.sv
// Multi-port PE register file: channel loads, FU write-back with priority,
// per-entry valid bits, combinational FU/output reads and a sequenced clear.
// Define PE_RF_BYPASS_EN to forward same-cycle writes onto the read paths.
module pe_regfile_mp
    import pe_rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int N_IN   = 3,
    parameter int N_RD   = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N_IN*DATA_W-1:0] ch_in,
    input  logic                   in_we,
    input  logic [N_IN-1:0]        in_sel,
    input  logic [AW-1:0]          in_addr,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [N_RD*N_IN-1:0]   rd_sel,
    input  logic [N_RD*AW-1:0]     rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_valid,
    input  logic [AW-1:0]          send_addr,
    input  logic [N_IN-1:0]        out_en,
    output logic [N_IN*DATA_W-1:0] ch_out,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   sel_err,
    output logic                   coll
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid, valid_nxt;
    pe_rf_state_e      state, state_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;

    logic [DATA_W-1:0] ld_data;
    logic              ld_legal;
    logic              ld_fire, wb_fire, coll_hit, ld_do;

    assign busy = (state == PE_RF_CLEAR);

    pe_rf_onehot_mux #(.N(N_IN), .W(DATA_W)) u_ld_mux (
        .sel      (in_sel),
        .data_in  (ch_in),
        .data_out (ld_data),
        .legal    (ld_legal)
    );

    // Write qualification: busy blocks both writers, write-back wins a collision
    assign ld_fire  = in_we & ld_legal & ~busy;
    assign wb_fire  = wb_en & ~busy;
    assign coll_hit = ld_fire & wb_fire & (in_addr == wb_addr);
    assign ld_do    = ld_fire & ~coll_hit;

    // Data array update; the two writers never share an address here
    // NOTE: the data array has no reset; the valid vector alone gates what readers see.
    always_ff @(posedge CLK) begin
        if (ld_do)   mem[in_addr] <= ld_data;
        if (wb_fire) mem[wb_addr] <= wb_data;
    end

    // Next valid vector: clear one entry per CLEAR cycle, else mark writes
    always_comb begin
        valid_nxt = valid;
        if (busy) begin
            valid_nxt[cnt] = 1'b0;
        end else begin
            if (ld_do)   valid_nxt[in_addr] = 1'b1;
            if (wb_fire) valid_nxt[wb_addr] = 1'b1;
        end
    end

    // Clear sequencer next-state: DEPTH cycles in CLEAR, counter wraps on exit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            PE_RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = PE_RF_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            PE_RF_CLEAR: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1)) state_nxt = PE_RF_IDLE;
            end
            default: state_nxt = PE_RF_IDLE;
        endcase
    end

    // Control state, valid bits and the one-cycle error pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= PE_RF_IDLE;
            cnt     <= '0;
            valid   <= '0;
            sel_err <= 1'b0;
            coll    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            valid   <= valid_nxt;
            sel_err <= in_we & ~busy & ~ld_legal;
            coll    <= coll_hit;
        end
    end

    // FU read ports
    for (genvar r = 0; r < N_RD; r++) begin : g_rd
        logic [N_IN-1:0]   sel;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] mux_d;
        logic              mux_ok;
        logic [DATA_W-1:0] file_d;
        logic              file_v;

        assign sel  = rd_sel[r*N_IN +: N_IN];
        assign addr = rd_addr[r*AW +: AW];

        pe_rf_onehot_mux #(.N(N_IN), .W(DATA_W)) u_rd_mux (
            .sel      (sel),
            .data_in  (ch_in),
            .data_out (mux_d),
            .legal    (mux_ok)
        );

        // File-sourced operand, optionally forwarding this cycle's write
        always_comb begin
            file_v = valid[addr];
            file_d = file_v ? mem[addr] : '0;
`ifdef PE_RF_BYPASS_EN
            if (wb_fire && (wb_addr == addr)) begin
                file_d = wb_data;
                file_v = 1'b1;
            end else if (ld_do && (in_addr == addr)) begin
                file_d = ld_data;
                file_v = 1'b1;
            end
`endif
        end

        assign rd_data[r*DATA_W +: DATA_W] = (sel == '0) ? file_d : mux_d;
        assign rd_valid[r]                 = (sel == '0) ? file_v : mux_ok;
    end

    // Output-channel source entry, same forwarding rule as the read ports
    logic [DATA_W-1:0] send_d;

    // Resolve the entry broadcast on the enabled output channels
    always_comb begin
        send_d = valid[send_addr] ? mem[send_addr] : '0;
`ifdef PE_RF_BYPASS_EN
        if (wb_fire && (wb_addr == send_addr))     send_d = wb_data;
        else if (ld_do && (in_addr == send_addr))  send_d = ld_data;
`endif
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_out
        assign ch_out[i*DATA_W +: DATA_W] = out_en[i] ? send_d : '0;
    end

endmodule
